stdcore_ctx_pre: RTL and testbench

// - Credit-based val/rdy transmitter; drives the p/p_val producer side of a downstream FIFO (DEPTH entries).
// - Data passes a fixed LAT-cycle pipeline (wire/compute latency), so the FIFO cannot backpressure it.
// - Owns DEPTH credits: one consumed per accepted word, one returned per downstream pop (c_val && c_rdy).
// - Also checks the FIFO's p_rdy and flags any push it would drop.

---
 rtl/stdcore_ctx_pre_if.sv | 36 +++
 rtl/stdcore_ctx_pre.sv | 119 +++++++++++
 tb/tb_stdcore_ctx_pre.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/stdcore_ctx_pre_if.sv
// ---------------------------------------------------------------------------
// stdcore_ctx_pre_if
// Bundles the upstream val/rdy channel, the downstream FIFO producer side and
// the FIFO credit-return pulse of the credit-based transmitter.
//
//   s       upstream data          (environment -> transmitter)
//   s_val   upstream valid         (environment -> transmitter)
//   s_rdy   upstream ready         (transmitter -> environment)
//   p       data to FIFO           (transmitter -> FIFO)
//   p_val   valid to FIFO          (transmitter -> FIFO)
//   p_rdy   FIFO ready, check only (FIFO -> transmitter)
//   cr_ret  credit return pulse    (FIFO c_val && c_rdy -> transmitter)
//
// Modports: slave = transmitter view, master = surrounding environment view.
// ---------------------------------------------------------------------------
interface stdcore_ctx_pre_if #(
  parameter int DW = 1
);
  logic [DW-1:0] s;
  logic          s_val;
  logic          s_rdy;
  logic [DW-1:0] p;
  logic          p_val;
  logic          p_rdy;
  logic          cr_ret;

  modport slave (
    input  s, s_val, p_rdy, cr_ret,
    output s_rdy, p, p_val
  );

  modport master (
    output s, s_val, p_rdy, cr_ret,
    input  s_rdy, p, p_val
  );
endinterface

// File: rtl/stdcore_ctx_pre.sv
// ---------------------------------------------------------------------------
// stdcore_ctx_pre
// Credit-based val/rdy transmitter feeding the producer side of a DEPTH-entry
// FIFO through a fixed LAT-stage pipeline that can never stall. The block owns
// DEPTH credits: one is spent per accepted word and one comes back per FIFO
// pop. Because the pipeline cannot be backpressured, p_rdy is only monitored;
// a push the FIFO would drop, or a credit returned with none outstanding, sets
// a sticky error flag.
//
// Ports
//   clk     clock, all state on posedge
//   arst_n  asynchronous reset, active-low
//   rst_n   synchronous clear, active-low
//   bus     stdcore_ctx_pre_if.slave (s/s_val/s_rdy, p/p_val/p_rdy, cr_ret)
//   cr      current credit count, registered
//   err     sticky error flag, registered, cleared only by reset
//
// Parameters
//   DW     data width
//   DEPTH  downstream FIFO entries = initial credits (>=1)
//   LAT    cycles from the accept cycle to p_val (>=1)
//   CW     credit counter width, must hold DEPTH+1
// ---------------------------------------------------------------------------
module stdcore_ctx_pre #(
  parameter int DW    = 1,
  parameter int DEPTH = 4,
  parameter int LAT   = 1,
  parameter int CW    = 9
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 rst_n,
  stdcore_ctx_pre_if.slave     bus,
  output logic [CW-1:0]        cr,
  output logic                 err
);

  localparam logic [CW-1:0] CR_INIT = CW'(DEPTH);

  logic          s_rdy_q;
  logic          acc;
  logic [CW-1:0] cr_nxt;
  logic          over_ret;

  // Pipeline stages; index LAT-1 drives the FIFO.
  logic          st_val  [LAT];
  logic [DW-1:0] st_data [LAT];

  assign acc       = bus.s_val && s_rdy_q;
  assign bus.s_rdy = s_rdy_q;
  assign bus.p     = st_data[LAT-1];
  assign bus.p_val = st_val[LAT-1];

  // Next credit count. A return while every credit is already home has no
  // matching outstanding word: the counter saturates and the event is flagged.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    cr_nxt   = cr;
    over_ret = 1'b0;
    if (bus.cr_ret && !acc && cr == CR_INIT) begin
      over_ret = 1'b1;
    end else begin
      cr_nxt = cr - CW'(acc) + CW'(bus.cr_ret);
    end
  end

  // Credit counter, ready and error flag. s_rdy comes from the next count so
  // the last credit drops ready in the cycle after it is spent.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cr      <= CR_INIT;
      s_rdy_q <= 1'b0;
      err     <= 1'b0;
    end else if (!rst_n) begin
      cr      <= CR_INIT;
      s_rdy_q <= 1'b0;
      err     <= 1'b0;
    end else begin
      cr      <= cr_nxt;
      s_rdy_q <= (cr_nxt != '0);
      if (over_ret || (st_val[LAT-1] && !bus.p_rdy)) begin
        err <= 1'b1;
      end
    end
  end

  // Fixed-latency pipeline. Valid bits shift every cycle; a stage only loads
  // data when a valid word arrives, so p keeps the last word delivered.
  // NOTE: the data stages are reset as well as the valid bits, because a
  // clean zero on p after reset is part of the visible interface.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < LAT; i++) begin
        st_val[i]  <= 1'b0;
        st_data[i] <= '0;
      end
    end else if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        st_val[i]  <= 1'b0;
        st_data[i] <= '0;
      end
    end else begin
      st_val[0] <= acc;
      if (acc) begin
        st_data[0] <= bus.s;
      end
      for (int i = 1; i < LAT; i++) begin
        st_val[i] <= st_val[i-1];
        if (st_val[i-1]) begin
          st_data[i] <= st_data[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_stdcore_ctx_pre.sv
// ---------------------------------------------------------------------------
// tb_stdcore_ctx_pre
// Directed bench for stdcore_ctx_pre with DW=8, DEPTH=4, LAT=2. Inputs change
// 1 time unit after a rising edge; outputs are checked at the same point, so
// each check sees the state produced by the edge just passed.
// ---------------------------------------------------------------------------
module tb_stdcore_ctx_pre;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int CW    = 9;

  logic          clk;
  logic          arst_n;
  logic          rst_n;
  logic [CW-1:0] cr;
  logic          err;

  int n_cmp;
  int n_bad;

  stdcore_ctx_pre_if #(.DW(DW)) bus ();

  stdcore_ctx_pre #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .LAT   (LAT),
    .CW    (CW)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .rst_n  (rst_n),
    .bus    (bus),
    .cr     (cr),
    .err    (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-computed burst response: words 1..6 offered back to back, 4 credits.
  logic [CW-1:0] burst_cr   [6] = '{9'd3, 9'd2, 9'd1, 9'd0, 9'd0, 9'd0};
  logic          burst_rdy  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic          burst_pval [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [DW-1:0] burst_p    [6] = '{8'h0, 8'h1, 8'h2, 8'h3, 8'h4, 8'h4};

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    bus.s      = '0;
    bus.s_val  = 1'b0;
    bus.p_rdy  = 1'b1;
    bus.cr_ret = 1'b0;
    arst_n     = 1'b0;
    rst_n      = 1'b0;

    // Reset state
    step();
    step();
    check("rst_s_rdy", 32'(bus.s_rdy), 32'd0);
    check("rst_cr",    32'(cr),        32'd4);
    check("rst_p_val", 32'(bus.p_val), 32'd0);
    check("rst_p",     32'(bus.p),     32'd0);
    check("rst_err",   32'(err),       32'd0);

    // Release: ready rises one edge later
    arst_n = 1'b1;
    rst_n  = 1'b1;
    check("rel_s_rdy0", 32'(bus.s_rdy), 32'd0);
    step();
    check("rel_s_rdy1", 32'(bus.s_rdy), 32'd1);
    check("rel_cr",     32'(cr),        32'd4);
    check("rel_err",    32'(err),       32'd0);

    // Burst of 6 offers, only 4 credits
    for (int i = 0; i < 6; i++) begin
      bus.s     = DW'(i + 1);
      bus.s_val = 1'b1;
      step();
      check($sformatf("burst_cr_%0d", i),   32'(cr),        32'(burst_cr[i]));
      check($sformatf("burst_rdy_%0d", i),  32'(bus.s_rdy), 32'(burst_rdy[i]));
      check($sformatf("burst_pval_%0d", i), 32'(bus.p_val), 32'(burst_pval[i]));
      check($sformatf("burst_p_%0d", i),    32'(bus.p),     32'(burst_p[i]));
    end
    bus.s_val = 1'b0;

    // Starved return: one credit back, then word 5 takes it
    bus.cr_ret = 1'b1;
    step();
    bus.cr_ret = 1'b0;
    check("starve_cr1",  32'(cr),        32'd1);
    check("starve_rdy1", 32'(bus.s_rdy), 32'd1);
    bus.s     = 8'h05;
    bus.s_val = 1'b1;
    step();
    bus.s_val = 1'b0;
    check("starve_cr0",  32'(cr),        32'd0);
    check("starve_rdy0", 32'(bus.s_rdy), 32'd0);
    check("starve_pv0",  32'(bus.p_val), 32'd0);
    step();
    check("starve_pv1",  32'(bus.p_val), 32'd1);
    check("starve_p",    32'(bus.p),     32'h05);
    step();
    check("starve_pv2",  32'(bus.p_val), 32'd0);
    check("starve_hold", 32'(bus.p),     32'h05);

    // Bring credits to 2, then accept and return in the same cycle
    bus.cr_ret = 1'b1;
    step();
    step();
    check("sim_cr_pre", 32'(cr), 32'd2);
    bus.s     = 8'h07;
    bus.s_val = 1'b1;
    step();
    bus.s_val  = 1'b0;
    bus.cr_ret = 1'b0;
    check("sim_cr",  32'(cr),        32'd2);
    check("sim_rdy", 32'(bus.s_rdy), 32'd1);
    step();
    check("sim_pv",  32'(bus.p_val), 32'd1);
    check("sim_p",   32'(bus.p),     32'h07);
    step();
    check("sim_pv0", 32'(bus.p_val), 32'd0);

    // Refill to DEPTH
    bus.cr_ret = 1'b1;
    step();
    step();
    bus.cr_ret = 1'b0;
    check("refill_cr",  32'(cr),  32'd4);
    check("refill_err", 32'(err), 32'd0);

    // Synchronous clear with two words in flight
    bus.s     = 8'h08;
    bus.s_val = 1'b1;
    step();
    bus.s = 8'h09;
    step();
    check("mid_cr",  32'(cr),        32'd2);
    check("mid_pv",  32'(bus.p_val), 32'd1);
    check("mid_p",   32'(bus.p),     32'h08);
    bus.s_val = 1'b0;
    rst_n     = 1'b0;
    step();
    check("mid_rst_pv",  32'(bus.p_val), 32'd0);
    check("mid_rst_p",   32'(bus.p),     32'd0);
    check("mid_rst_cr",  32'(cr),        32'd4);
    check("mid_rst_rdy", 32'(bus.s_rdy), 32'd0);
    rst_n = 1'b1;
    step();
    check("mid_rel_rdy", 32'(bus.s_rdy), 32'd1);
    check("mid_rel_pv",  32'(bus.p_val), 32'd0);
    step();
    check("mid_rel_pv2", 32'(bus.p_val), 32'd0);

    // Over-return at full credits
    bus.cr_ret = 1'b1;
    step();
    bus.cr_ret = 1'b0;
    check("over_cr",  32'(cr),  32'd4);
    check("over_err", 32'(err), 32'd1);
    step();
    check("over_sticky", 32'(err), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("over_clr", 32'(err), 32'd0);
    step();

    // Push while the FIFO is not ready
    bus.p_rdy = 1'b0;
    bus.s     = 8'h0A;
    bus.s_val = 1'b1;
    step();
    bus.s_val = 1'b0;
    step();
    check("drop_pv",   32'(bus.p_val), 32'd1);
    check("drop_err0", 32'(err),       32'd0);
    step();
    check("drop_err1", 32'(err),       32'd1);
    bus.p_rdy = 1'b1;
    step();
    check("drop_sticky", 32'(err), 32'd1);
    check("drop_cr",     32'(cr),  32'd3);

    // Asynchronous reset acts without a clock edge
    #2;
    arst_n = 1'b0;
    #1;
    check("arst_cr",  32'(cr),        32'd4);
    check("arst_err", 32'(err),       32'd0);
    check("arst_rdy", 32'(bus.s_rdy), 32'd0);
    arst_n = 1'b1;
    step();
    check("arst_rel_rdy", 32'(bus.s_rdy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
